systolic_writeback_ctrl: RTL and testbench
==========================================

// Module: systolic_writeback_ctrl
// PURPOSE
//  Drains one NxN tile from the systolic array into output SRAM banks. It accepts 2N-1 skewed
//  diagonal vectors over a valid/ready handshake and de-skews (packs) each into one SRAM row.
//  It generates its own row counter and writes to a run-time selected bank from a base address.
//  A one-entry output register stalls on SRAM backpressure. Sits between quantizer and SRAM.
// PARAMETERS
//  ARRAY_SIZE  32  N, PE rows/cols; lanes per vector
//  DATA_WIDTH  32  bits per lane
//  ADDR_WIDTH  7   SRAM row address width (2^ADDR_WIDTH >= 2N-1 at defaults)
//  NUM_BANKS   3   output banks; one active-low write enable each
//  BS_W = max(1,$clog2(NUM_BANKS)), K_W = $clog2(2N) (localparams)
// PORTS
//  clk         in   1            clock
//  srstn       in   1            synchronous active-low reset
//  start       in   1            begin a tile; sampled only in IDLE
//  bank_sel    in   BS_W         target bank, latched at start
//  base_addr   in   ADDR_WIDTH   first row address, latched at start
//  mode        in   1            0 = de-skew pack, 1 = raw pass-through; latched at start
//  in_valid    in   1            diagonal vector valid
//  in_ready    out  1            vector accepted when in_valid & in_ready
//  in_data     in   N*DW         lane i = in_data[i*DW +: DW]
//  sram_ready  in   1            SRAM takes the pending write this cycle
//  sram_wen_n  out  NUM_BANKS    active-low write enable, one-hot-low on bank_sel
//  sram_waddr  out  ADDR_WIDTH   row address
//  sram_wdata  out  N*DW         packed row
//  busy        out  1            high in RUN and FLUSH
//  done        out  1            1-cycle pulse, tile fully written
//  err         out  1            1-cycle pulse, start rejected
// BEHAVIOUR
//  Reset: state IDLE, k=0, pending=0. sram_wen_n all 1. waddr, wdata, busy, done, err = 0.
//   in_ready = 0. A pending write is discarded on reset, including mid-tile.
//  FSM: IDLE -start & bank_sel<NUM_BANKS-> RUN (latch cfg, k=0).
//   RUN -accept with k==2N-2-> FLUSH.
//   FLUSH -pending write handshakes-> DONE. DONE -> IDLE (done=1 for this one cycle).
//  start in IDLE with bank_sel>=NUM_BANKS: err=1 next cycle, stay IDLE.
//  start while busy or in DONE: ignored, err=1 next cycle, latched config unchanged.
//  in_ready = (state==RUN) & (~pending | sram_ready). This path is combinational.
//  Accept at cycle t: output register loads and sram_wen_n[bank]=0 at t+1.
//   The write completes in the first cycle where pending & sram_ready. Then pending=0 and
//   wen_n returns to all 1, unless a new accept in the same cycle reloads it.
//   This gives back-to-back rows with no bubble.
//  Stall (pending & ~sram_ready): wen_n, waddr and wdata hold stable. in_ready=0. No data loss.
//  Address = base_addr + k, modulo 2^ADDR_WIDTH, with wrap-around.
//  Pack, mode 0, out lane N-1-i gets:
//   k<N: in[i] if i<=k, else 0.
//   k>=N: in[i+1+k-N] if i<2N-1-k, else 0.
//  Pack, mode 1: out lane N-1-i = in[i] for all i.
//  k increments per accept. It never exceeds 2N-2. Exactly 2N-1 writes per tile.
// TESTING (bench uses ARRAY_SIZE=4, DATA_WIDTH=8 plus one default-parameter smoke run)
//  1 Clean tile: start bank 1, base 0x10, mode 0, in_valid=1, sram_ready=1, in={04,03,02,01}.
//    -> wen_n=3'b101 for 7 cycles; addrs 0x10..0x16.
//    -> k=0 wdata 0x01000000; k=4 wdata 0x02030400; k=6 wdata 0x04000000.
//    -> done pulses 1 cycle after the 7th write.
//  2 Backpressure: sram_ready=0 for 3 cycles at k=2.
//    -> addr 0x12 and its data held, in_ready=0; all 7 rows written in order.
//  3 Wrap: base 0x7E, mode 0.
//    -> addrs 0x7E, 0x7F, 0x00, 0x01, 0x02, 0x03, 0x04.
//  4 Errors: start while busy -> err 1 cycle, tile continues with original config.
//    bank_sel=3 in IDLE -> err 1 cycle, busy stays 0, no writes.
//  5 Reset mid-tile at k=3 -> next cycle wen_n=3'b111, busy=0, in_ready=0.
//    Then a new start writes from k=0 at its base.
//  6 Mode 1, in={04,03,02,01}.
//    -> every row wdata=0x01020304; 7 rows; done pulse.

Source files
------------

// File: rtl/systolic_writeback_ctrl.sv
// Drains one NxN systolic tile: de-skews 2N-1 diagonal vectors into SRAM rows
// through a one-entry output register that holds steady under SRAM backpressure.
module systolic_writeback_ctrl #(
  parameter int unsigned ARRAY_SIZE = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned NUM_BANKS  = 3,
  localparam int unsigned BS_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned K_W   = $clog2(2 * ARRAY_SIZE),
  localparam int unsigned ROW_W = ARRAY_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic [BS_W-1:0]       bank_sel,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROW_W-1:0]      in_data,
  input  logic                  sram_ready,
  output logic [NUM_BANKS-1:0]  sram_wen_n,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [ROW_W-1:0]      sram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} state_e;

  localparam logic [K_W-1:0] K_LAST = K_W'(2 * ARRAY_SIZE - 2);

  state_e                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic                  pending_q, pending_d;
  logic [BS_W-1:0]       bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  mode_q, mode_d;
  logic [NUM_BANKS-1:0]  wen_n_q, wen_n_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ROW_W-1:0]      wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept_c;
  logic                  drain_c;
  logic                  bank_ok_c;
  logic [31:0]           k_ext_c;
  logic [ROW_W-1:0]      pack_c;

  // A new vector may enter whenever the output register is empty or emptying now.
  assign in_ready  = (state_q == ST_RUN) && (!pending_q || sram_ready);
  assign accept_c  = in_valid && in_ready;
  assign drain_c   = pending_q && sram_ready;
  assign bank_ok_c = 32'(bank_sel) < NUM_BANKS;
  assign k_ext_c   = 32'(k_q);

  // Diagonal k carries lanes that belong to the rising/falling edge of the tile.
  always_comb begin
    pack_c = '0;
    for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
      if (mode_q) begin
        pack_c[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (k_ext_c < ARRAY_SIZE) begin
        if (i <= k_ext_c) begin
          pack_c[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (i + k_ext_c < 2 * ARRAY_SIZE - 1) begin
        pack_c[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] =
          in_data[(i + 1 + k_ext_c - ARRAY_SIZE)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pending_d = pending_q;
    bank_d    = bank_q;
    base_d    = base_q;
    mode_d    = mode_q;
    wen_n_d   = wen_n_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (bank_ok_c) begin
            state_d = ST_RUN;
            k_d     = '0;
            bank_d  = bank_sel;
            base_d  = base_addr;
            mode_d  = mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        err_d = start;
        if (accept_c) begin
          if (k_q == K_LAST) begin
            state_d = ST_FLUSH;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        err_d = start;
        if (!pending_q || sram_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = start;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reload on accept wins over retiring, so consecutive rows leave no bubble.
    if (accept_c) begin
      pending_d = 1'b1;
      waddr_d   = ADDR_WIDTH'(base_q + ADDR_WIDTH'(k_q));
      wdata_d   = pack_c;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        wen_n_d[b] = (32'(bank_q) != b);
      end
    end else if (drain_c) begin
      pending_d = 1'b0;
      wen_n_d   = '1;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      pending_q <= 1'b0;
      bank_q    <= '0;
      base_q    <= '0;
      mode_q    <= 1'b0;
      wen_n_q   <= '1;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
      base_q    <= base_d;
      mode_q    <= mode_d;
      wen_n_q   <= wen_n_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign sram_wen_n = wen_n_q;
  assign sram_waddr = waddr_q;
  assign sram_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_systolic_writeback_ctrl.sv
// Bench for systolic_writeback_ctrl: scoreboard of expected SRAM writes plus
// per-scenario tasks on a 4x4/8-bit instance and a default-parameter smoke instance.
module tb_systolic_writeback_ctrl;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int RW  = N * DW;
  localparam int N2  = 32;
  localparam int DW2 = 32;
  localparam int RW2 = N2 * DW2;

  localparam logic [6:0] WRAP_EXP [7] = '{7'h7E, 7'h7F, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04};

  typedef struct {
    logic [2:0]    wen;
    logic [6:0]    addr;
    logic [RW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          srstn;
  logic          start, mode, in_valid, sram_ready;
  logic [1:0]    bank_sel;
  logic [6:0]    base_addr;
  logic [RW-1:0] in_data;
  logic          in_ready, busy, done, err;
  logic [2:0]    sram_wen_n;
  logic [6:0]    sram_waddr;
  logic [RW-1:0] sram_wdata;

  logic           start2, mode2, in_valid2, sram_ready2;
  logic [1:0]     bank_sel2;
  logic [6:0]     base_addr2;
  logic [RW2-1:0] in_data2;
  logic           in_ready2, busy2, done2, err2;
  logic [2:0]     sram_wen_n2;
  logic [6:0]     sram_waddr2;
  logic [RW2-1:0] sram_wdata2;

  int total = 0;
  int bad   = 0;
  int wr_cnt;
  int m_k;
  logic [1:0] m_bank;
  logic [6:0] m_base;
  logic       m_mode;
  exp_t sb [$];
  exp_t mon_e;
  logic [6:0]    log_addr [$];
  logic [RW-1:0] log_data [$];
  logic [2:0]    log_wen  [$];

  always #5 clk = ~clk;

  systolic_writeback_ctrl #(
    .ARRAY_SIZE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(7), .NUM_BANKS(3)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start), .bank_sel(bank_sel), .base_addr(base_addr),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sram_ready(sram_ready), .sram_wen_n(sram_wen_n), .sram_waddr(sram_waddr),
    .sram_wdata(sram_wdata), .busy(busy), .done(done), .err(err)
  );

  systolic_writeback_ctrl dut_def (
    .clk(clk), .srstn(srstn), .start(start2), .bank_sel(bank_sel2), .base_addr(base_addr2),
    .mode(mode2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .sram_ready(sram_ready2), .sram_wen_n(sram_wen_n2), .sram_waddr(sram_waddr2),
    .sram_wdata(sram_wdata2), .busy(busy2), .done(done2), .err(err2)
  );

  // Reference de-skew: output lane j comes from diagonal position N-1-j.
  function automatic logic [RW-1:0] model_row(input int k, input logic md, input logic [RW-1:0] d);
    logic [RW-1:0] r;
    int src;
    int pos;
    r = '0;
    for (int j = 0; j < N; j++) begin
      pos = N - 1 - j;
      src = -1;
      if (md) src = pos;
      else if (k < N) begin
        if (pos <= k) src = pos;
      end else begin
        src = pos + 1 + k - N;
        if (src > N - 1) src = -1;
      end
      if (src >= 0) r[j*DW +: DW] = d[src*DW +: DW];
    end
    return r;
  endfunction

  // Scoreboard: pop on each completing write, push on each accepted vector.
  always @(negedge clk) begin
    if (srstn === 1'b1) begin
      if (sram_wen_n !== 3'b111 && sram_ready === 1'b1) begin
        wr_cnt++;
        log_addr.push_back(sram_waddr);
        log_data.push_back(sram_wdata);
        log_wen.push_back(sram_wen_n);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_write: got addr=%h data=%h, want no write", sram_waddr, sram_wdata);
        end else begin
          mon_e = sb.pop_front();
          if ({sram_wen_n, sram_waddr, sram_wdata} !== {mon_e.wen, mon_e.addr, mon_e.data}) begin
            bad++;
            $display("FAIL sb_write: got wen=%b addr=%h data=%h, want wen=%b addr=%h data=%h",
                     sram_wen_n, sram_waddr, sram_wdata, mon_e.wen, mon_e.addr, mon_e.data);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        mon_e.wen = 3'b111;
        mon_e.wen[m_bank] = 1'b0;
        mon_e.addr = 7'(m_base + 7'(m_k));
        mon_e.data = model_row(m_k, m_mode, in_data);
        sb.push_back(mon_e);
        m_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [1:0] b, input logic [6:0] a, input logic md);
    m_bank = b; m_base = a; m_mode = md; m_k = 0; wr_cnt = 0;
    log_addr.delete(); log_data.delete(); log_wen.delete();
    bank_sel = b; base_addr = a; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observe until done (returns at the negedge where done is seen) or budget expires.
  task automatic run_until_done(input int budget, output int last_wr, output int done_at);
    last_wr = -1;
    done_at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sram_wen_n !== 3'b111 && sram_ready === 1'b1) last_wr = c;
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    srstn = 1'b0; in_valid = 1'b1; sram_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++;
    if ({sram_wen_n, sram_waddr, sram_wdata, busy, done, err, in_ready} !== {3'b111, 7'h0, 32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outputs: got wen=%b addr=%h data=%h b/d/e/r=%b%b%b%b, want 111/00/0/0000",
               sram_wen_n, sram_waddr, sram_wdata, busy, done, err, in_ready);
    end
    total++;
    if ({sram_wen_n2, sram_waddr2, busy2, done2, err2, in_ready2} !== {3'b111, 7'h0, 4'b0000} || sram_wdata2 !== '0) begin
      bad++;
      $display("FAIL reset_default_inst: got wen=%b addr=%h b/d/e/r=%b%b%b%b", sram_wen_n2, sram_waddr2,
               busy2, done2, err2, in_ready2);
    end
    tick();
    srstn = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_ready: got in_ready=%b busy=%b, want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clean();
    int last_wr, done_at;
    in_data = 32'h04030201; in_valid = 1'b1; sram_ready = 1'b1;
    start_tile(2'd1, 7'h10, 1'b0);
    run_until_done(40, last_wr, done_at);
    total++;
    if (done_at < 0 || done_at != last_wr + 1) begin
      bad++;
      $display("FAIL clean_done_timing: got done_at=%0d last_write=%0d, want done one cycle after last write", done_at, last_wr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clean_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
    end
    total++;
    if (wr_cnt != 7 || sb.size() != 0) begin
      bad++;
      $display("FAIL clean_count: got writes=%0d pending_exp=%0d, want 7 0", wr_cnt, sb.size());
    end
    if (log_addr.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (log_addr[i] !== 7'(8'h10 + i) || log_wen[i] !== 3'b101) begin
          bad++;
          $display("FAIL clean_addr_%0d: got addr=%h wen=%b, want %h 101", i, log_addr[i], log_wen[i], 7'(8'h10 + i));
        end
      end
      total++;
      if (log_data[0] !== 32'h01000000) begin
        bad++; $display("FAIL clean_k0: got %h want 01000000", log_data[0]);
      end
      total++;
      if (log_data[4] !== 32'h02030400) begin
        bad++; $display("FAIL clean_k4: got %h want 02030400", log_data[4]);
      end
      total++;
      if (log_data[6] !== 32'h04000000) begin
        bad++; $display("FAIL clean_k6: got %h want 04000000", log_data[6]);
      end
    end
  endtask

  task automatic test_backpressure();
    int last_wr, done_at;
    in_data = 32'h04030201; in_valid = 1'b1; sram_ready = 1'b1;
    start_tile(2'd1, 7'h10, 1'b0);
    repeat (3) tick();
    sram_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({in_ready, sram_wen_n, sram_waddr, sram_wdata} !== {1'b0, 3'b101, 7'h12, 32'h01020300}) begin
        bad++;
        $display("FAIL stall_hold_%0d: got rdy=%b wen=%b addr=%h data=%h, want 0 101 12 01020300",
                 c, in_ready, sram_wen_n, sram_waddr, sram_wdata);
      end
      tick();
    end
    sram_ready = 1'b1;
    run_until_done(40, last_wr, done_at);
    in_valid = 1'b0;
    total++;
    if (done_at < 0 || wr_cnt != 7 || sb.size() != 0) begin
      bad++;
      $display("FAIL stall_complete: got done_at=%0d writes=%0d left=%0d, want done 7 0", done_at, wr_cnt, sb.size());
    end
  endtask

  task automatic test_wrap();
    int last_wr, done_at;
    in_data = 32'h0d0c0b0a; in_valid = 1'b1; sram_ready = 1'b1;
    start_tile(2'd0, 7'h7E, 1'b0);
    run_until_done(40, last_wr, done_at);
    in_valid = 1'b0;
    total++;
    if (done_at < 0 || wr_cnt != 7) begin
      bad++;
      $display("FAIL wrap_count: got done_at=%0d writes=%0d, want done 7", done_at, wr_cnt);
    end
    if (log_addr.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        total++;
        if (log_addr[i] !== WRAP_EXP[i] || log_wen[i] !== 3'b110) begin
          bad++;
          $display("FAIL wrap_addr_%0d: got addr=%h wen=%b, want %h 110", i, log_addr[i], log_wen[i], WRAP_EXP[i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    int last_wr, done_at;
    in_data = 32'h0a0b0c0d; in_valid = 1'b1; sram_ready = 1'b1;
    start_tile(2'd2, 7'h30, 1'b0);
    tick();
    bank_sel = 2'd0; base_addr = 7'h55; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_busy_start: got err=%b want 1", err);
    end
    tick();
    @(negedge clk);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL err_pulse_len: got err=%b busy=%b want 0 1", err, busy);
    end
    run_until_done(40, last_wr, done_at);
    in_valid = 1'b0;
    total++;
    if (done_at < 0 || wr_cnt != 7 || sb.size() != 0) begin
      bad++;
      $display("FAIL err_tile_intact: got done_at=%0d writes=%0d left=%0d, want done 7 0", done_at, wr_cnt, sb.size());
    end
    // Start arriving while in DONE is rejected too.
    bank_sel = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_done_start: got err=%b busy=%b want 1 0", err, busy);
    end
    wr_cnt = 0;
    bank_sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_bad_bank: got err=%b busy=%b want 1 0", err, busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (err !== 1'b0 || busy !== 1'b0 || sram_wen_n !== 3'b111) begin
      bad++; $display("FAIL err_bad_bank_after: got err=%b busy=%b wen=%b want 0 0 111", err, busy, sram_wen_n);
    end
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    total++;
    if (wr_cnt != 0 || sb.size() != 0) begin
      bad++; $display("FAIL err_bad_bank_writes: got writes=%0d accepts=%0d want 0 0", wr_cnt, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int last_wr, done_at;
    in_data = 32'h11223344; in_valid = 1'b1; sram_ready = 1'b1;
    start_tile(2'd1, 7'h20, 1'b0);
    repeat (3) tick();
    srstn = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if ({sram_wen_n, busy, in_ready} !== {3'b111, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midreset_outputs: got wen=%b busy=%b in_ready=%b want 111 0 0", sram_wen_n, busy, in_ready);
    end
    sb.delete();
    srstn = 1'b1;
    tick();
    start_tile(2'd2, 7'h40, 1'b0);
    run_until_done(40, last_wr, done_at);
    in_valid = 1'b0;
    total++;
    if (done_at < 0 || wr_cnt != 7 || sb.size() != 0) begin
      bad++;
      $display("FAIL midreset_restart: got done_at=%0d writes=%0d left=%0d, want done 7 0", done_at, wr_cnt, sb.size());
    end
    if (log_addr.size() > 0) begin
      total++;
      if (log_addr[0] !== 7'h40 || log_data[0] !== 32'h44000000 || log_wen[0] !== 3'b011) begin
        bad++;
        $display("FAIL midreset_first_row: got addr=%h data=%h wen=%b want 40 44000000 011",
                 log_addr[0], log_data[0], log_wen[0]);
      end
    end
  endtask

  task automatic test_mode1();
    int last_wr, done_at;
    in_data = 32'h04030201; in_valid = 1'b1; sram_ready = 1'b1;
    start_tile(2'd0, 7'h00, 1'b1);
    run_until_done(40, last_wr, done_at);
    in_valid = 1'b0;
    total++;
    if (done_at < 0 || wr_cnt != 7) begin
      bad++; $display("FAIL mode1_count: got done_at=%0d writes=%0d want done 7", done_at, wr_cnt);
    end
    for (int i = 0; i < log_data.size(); i++) begin
      total++;
      if (log_data[i] !== 32'h01020304) begin
        bad++; $display("FAIL mode1_row_%0d: got %h want 01020304", i, log_data[i]);
      end
    end
  endtask

  task automatic test_random();
    int done_at;
    done_at = -1;
    start_tile(2'd2, 7'($urandom_range(0, 127)), 1'b0);
    for (int c = 0; c < 300; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = $urandom;
      sram_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0; sram_ready = 1'b1;
    total++;
    if (done_at < 0 || wr_cnt != 7 || sb.size() != 0) begin
      bad++;
      $display("FAIL random_tile: got done_at=%0d writes=%0d left=%0d, want done 7 0", done_at, wr_cnt, sb.size());
    end
  endtask

  task automatic test_smoke_default();
    logic [RW2-1:0] exp2;
    int idx, done_at;
    idx = 0; done_at = -1; exp2 = '0;
    for (int i = 0; i < N2; i++) begin
      in_data2[i*DW2 +: DW2] = DW2'(i + 1);
      exp2[(N2-1-i)*DW2 +: DW2] = DW2'(i + 1);
    end
    bank_sel2 = 2'd2; base_addr2 = 7'h05; mode2 = 1'b1; start2 = 1'b1;
    in_valid2 = 1'b1; sram_ready2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        done_at = c;
        break;
      end
      if (sram_wen_n2 !== 3'b111 && sram_ready2 === 1'b1) begin
        total++;
        if ({sram_wen_n2, sram_waddr2, sram_wdata2} !== {3'b011, 7'(7'h05 + idx), exp2}) begin
          bad++;
          $display("FAIL smoke_row_%0d: got wen=%b addr=%h top=%h low=%h, want 011 %h top=%h low=%h", idx,
                   sram_wen_n2, sram_waddr2, sram_wdata2[RW2-1 -: 32], sram_wdata2[31:0],
                   7'(7'h05 + idx), exp2[RW2-1 -: 32], exp2[31:0]);
        end
        idx++;
      end
    end
    in_valid2 = 1'b0;
    total++;
    if (done_at < 0 || idx != 2 * N2 - 1) begin
      bad++; $display("FAIL smoke_count: got done_at=%0d rows=%0d want done %0d", done_at, idx, 2 * N2 - 1);
    end
  endtask

  initial begin
    srstn = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; sram_ready = 1'b1;
    bank_sel = '0; base_addr = '0; in_data = '0;
    start2 = 1'b0; mode2 = 1'b0; in_valid2 = 1'b0; sram_ready2 = 1'b1;
    bank_sel2 = '0; base_addr2 = '0; in_data2 = '0;
    wr_cnt = 0; m_k = 0; m_bank = '0; m_base = '0; m_mode = 1'b0;
    test_reset();
    test_clean();
    tick();
    test_backpressure();
    tick();
    test_wrap();
    tick();
    test_errors();
    tick();
    test_reset_mid();
    tick();
    test_mode1();
    tick();
    test_random();
    tick();
    test_smoke_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
